// File: rtl/fifo_0r1w_flex.sv
// Flexible FIFO: combinational read of the head entry, one-cycle write, any DEPTH >= 1.
// Provides occupancy, almost-full/empty flags, synchronous flush and sticky error flags.
module fifo_0r1w_flex #(
   parameter int unsigned DWIDTH        = 32,
   parameter int unsigned DEPTH         = 32,
   parameter int unsigned AFULL_THRESH  = DEPTH - 1,
   parameter int unsigned AEMPTY_THRESH = 1
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_flush,
   input  logic                       i_push,
   input  logic [DWIDTH-1:0]          i_wdata,
   output logic                       o_full,
   output logic                       o_afull,
   input  logic                       i_pop,
   output logic [DWIDTH-1:0]          o_rdata,
   output logic                       o_empty,
   output logic                       o_aempty,
   output logic [$clog2(DEPTH+1)-1:0] o_count,
   output logic                       o_overflow,
   output logic                       o_underflow,
   input  logic                       i_clr_err
);

   localparam int unsigned CWIDTH = $clog2(DEPTH + 1);
   localparam int unsigned IWIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CWIDTH-1:0] DEPTH_C  = CWIDTH'(DEPTH);
   localparam logic [CWIDTH-1:0] AFULL_C  = CWIDTH'(AFULL_THRESH);
   localparam logic [CWIDTH-1:0] AEMPTY_C = CWIDTH'(AEMPTY_THRESH);

   logic [DWIDTH-1:0] mem [DEPTH];
   logic [IWIDTH-1:0] push_idx;
   logic [IWIDTH-1:0] pop_idx;
   logic [CWIDTH-1:0] count;
   logic              overflow;
   logic              underflow;
   logic              pop_ok;
   logic              push_ok;
   logic              ovf_set;
   logic              unf_set;

   function automatic logic [IWIDTH-1:0] next_idx(input logic [IWIDTH-1:0] idx);
      return (idx == IWIDTH'(DEPTH - 1)) ? '0 : idx + 1'b1;
   endfunction

   // Full/empty come from count, so all DEPTH slots hold data.
   always_comb begin
      pop_ok  = i_pop & (count != '0);
      push_ok = i_push & ((count != DEPTH_C) | pop_ok);
      ovf_set = i_push & ~push_ok & ~i_flush;
      unf_set = i_pop & ~pop_ok & ~i_flush;
   end

   always_ff @(posedge i_clk) begin
      if (push_ok && !i_flush) begin
         mem[push_idx] <= i_wdata;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         push_idx  <= '0;
         pop_idx   <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (i_flush) begin
            push_idx <= '0;
            pop_idx  <= '0;
            count    <= '0;
         end else begin
            if (push_ok) push_idx <= next_idx(push_idx);
            if (pop_ok)  pop_idx  <= next_idx(pop_idx);
            case ({push_ok, pop_ok})
               2'b10:   count <= count + 1'b1;
               2'b01:   count <= count - 1'b1;
               default: count <= count;
            endcase
         end
         // A set event in the same cycle outranks a clear.
         overflow  <= ovf_set | (overflow & ~i_clr_err);
         underflow <= unf_set | (underflow & ~i_clr_err);
      end
   end

   assign o_rdata     = mem[pop_idx];
   assign o_count     = count;
   assign o_full      = (count == DEPTH_C);
   assign o_empty     = (count == '0);
   assign o_afull     = (count >= AFULL_C);
   assign o_aempty    = (count <= AEMPTY_C);
   assign o_overflow  = overflow;
   assign o_underflow = underflow;

   int unsigned ptr_diff;
   always_comb ptr_diff = (32'(push_idx) + DEPTH - 32'(pop_idx)) % DEPTH;

   a_params: assert property (@(posedge i_clk)
      (DWIDTH >= 1) && (DEPTH >= 1) && (AFULL_THRESH >= 1) && (AFULL_THRESH <= DEPTH)
      && (AEMPTY_THRESH <= DEPTH - 1));
   a_count_range: assert property (@(posedge i_clk) disable iff (i_rst) count <= DEPTH_C);
   a_ptr_range: assert property (@(posedge i_clk) disable iff (i_rst)
      (32'(push_idx) < DEPTH) && (32'(pop_idx) < DEPTH));
   a_count_ptrs: assert property (@(posedge i_clk) disable iff (i_rst)
      (count == DEPTH_C) ? (push_idx == pop_idx) : (32'(count) == ptr_diff));

endmodule

// File: tb/tb_fifo_0r1w_flex.sv
// Scoreboard bench for fifo_0r1w_flex at DEPTH=5, DWIDTH=8.
module tb_fifo_0r1w_flex;
   localparam int unsigned DW = 8;
   localparam int unsigned DP = 5;

   logic          i_clk = 1'b0;
   logic          i_rst, i_flush, i_push, i_pop, i_clr_err;
   logic [DW-1:0] i_wdata;
   logic          o_full, o_afull, o_empty, o_aempty, o_overflow, o_underflow;
   logic [DW-1:0] o_rdata;
   logic [2:0]    o_count;

   int            errors = 0;
   int            checks = 0;
   logic [DW-1:0] sb [$];
   logic          m_ovf = 1'b0;
   logic          m_unf = 1'b0;

   fifo_0r1w_flex #(.DWIDTH(DW), .DEPTH(DP)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush), .i_push(i_push),
      .i_wdata(i_wdata), .o_full(o_full), .o_afull(o_afull), .i_pop(i_pop),
      .o_rdata(o_rdata), .o_empty(o_empty), .o_aempty(o_aempty), .o_count(o_count),
      .o_overflow(o_overflow), .o_underflow(o_underflow), .i_clr_err(i_clr_err)
   );

   always #5 i_clk = ~i_clk;

   // One clock of stimulus; popped data is compared against the scoreboard head.
   task automatic step(input logic push, input logic [DW-1:0] wd, input logic pop,
                       input logic flush, input logic clr);
      logic pop_ok, push_ok;
      @(negedge i_clk);
      i_push = push; i_wdata = wd; i_pop = pop; i_flush = flush; i_clr_err = clr;
      pop_ok  = pop && (sb.size() != 0);
      push_ok = push && ((sb.size() != DP) || pop_ok);
      #1;
      if (pop_ok && !flush) begin
         checks++;
         if (o_rdata !== sb[0]) begin
            errors++;
            $display("FAIL pop_data: got %0h expected %0h", o_rdata, sb[0]);
         end
      end
      @(posedge i_clk);
      if (flush) sb.delete();
      else begin
         if (pop_ok)  void'(sb.pop_front());
         if (push_ok) sb.push_back(wd);
      end
      m_ovf = (push && !push_ok && !flush) || (m_ovf && !clr);
      m_unf = (pop && !pop_ok && !flush) || (m_unf && !clr);
      #1;
      i_push = 0; i_pop = 0; i_flush = 0; i_clr_err = 0;
   endtask

   task automatic test_reset();
      i_rst = 1; i_flush = 0; i_push = 0; i_pop = 0; i_clr_err = 0; i_wdata = '0;
      repeat (2) @(posedge i_clk);
      #1;
      checks++;
      if ({o_empty, o_full, o_count, o_aempty, o_afull, o_overflow, o_underflow} !== 9'b1_0_000_1_0_0_0) begin
         errors++;
         $display("FAIL reset_state: got e%b f%b c%0d ae%b af%b ov%b un%b expected e1 f0 c0 ae1 af0 ov0 un0",
                  o_empty, o_full, o_count, o_aempty, o_afull, o_overflow, o_underflow);
      end
      @(negedge i_clk);
      i_rst = 0;
      @(posedge i_clk);
      #1;
      checks++;
      if (o_empty !== 1'b1 || o_count !== 3'd0) begin
         errors++;
         $display("FAIL idle_after_reset: got e%b c%0d expected e1 c0", o_empty, o_count);
      end
   endtask

   task automatic test_fill_drain();
      for (int i = 0; i < 5; i++) begin
         step(1, 8'hA0 + 8'(i), 0, 0, 0);
         checks++;
         if (o_count !== 3'(i + 1) || o_afull !== (i + 1 >= 4)) begin
            errors++;
            $display("FAIL fill_count: got c%0d af%b expected c%0d af%b", o_count, o_afull, i + 1, (i + 1 >= 4));
         end
      end
      checks++;
      if (o_full !== 1'b1 || o_empty !== 1'b0) begin
         errors++;
         $display("FAIL full_flag: got f%b e%b expected f1 e0", o_full, o_empty);
      end
      for (int i = 0; i < 5; i++) begin
         step(0, 8'h00, 1, 0, 0);
         checks++;
         if (o_aempty !== (4 - i <= 1) || o_full !== 1'b0) begin
            errors++;
            $display("FAIL drain_flags: got ae%b f%b expected ae%b f0", o_aempty, o_full, (4 - i <= 1));
         end
      end
      checks++;
      if (o_empty !== 1'b1 || o_count !== 3'd0) begin
         errors++;
         $display("FAIL drained_empty: got e%b c%0d expected e1 c0", o_empty, o_count);
      end
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 5; i++) step(1, 8'h50 + 8'(i), 0, 0, 0);
      step(1, 8'hBB, 0, 0, 0);
      checks++;
      if (o_overflow !== 1'b1 || o_count !== 3'd5) begin
         errors++;
         $display("FAIL overflow_drop: got ov%b c%0d expected ov1 c5", o_overflow, o_count);
      end
      step(1, 8'hCC, 1, 0, 0);
      checks++;
      if (o_count !== 3'd5 || o_rdata !== 8'h51) begin
         errors++;
         $display("FAIL push_pop_full: got c%0d head %0h expected c5 head 51", o_count, o_rdata);
      end
      for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 0, 0);
      checks++;
      if (o_rdata !== 8'hCC || o_count !== 3'd1) begin
         errors++;
         $display("FAIL last_is_cc: got %0h c%0d expected cc c1", o_rdata, o_count);
      end
      step(0, 8'h00, 1, 0, 1);
      checks++;
      if (o_overflow !== m_ovf || o_overflow !== 1'b0) begin
         errors++;
         $display("FAIL overflow_clear: got %b expected 0", o_overflow);
      end
   endtask

   task automatic test_underflow();
      step(0, 8'h00, 1, 0, 0);
      checks++;
      if (o_underflow !== 1'b1 || o_count !== 3'd0) begin
         errors++;
         $display("FAIL underflow_set: got un%b c%0d expected un1 c0", o_underflow, o_count);
      end
      step(0, 8'h00, 0, 0, 1);
      checks++;
      if (o_underflow !== 1'b0) begin
         errors++;
         $display("FAIL underflow_clr: got %b expected 0", o_underflow);
      end
      step(0, 8'h00, 1, 0, 1);
      checks++;
      if (o_underflow !== 1'b1) begin
         errors++;
         $display("FAIL set_beats_clr: got %b expected 1", o_underflow);
      end
      step(1, 8'h77, 1, 0, 0);
      checks++;
      if (o_count !== 3'd1 || o_rdata !== 8'h77 || o_underflow !== m_unf) begin
         errors++;
         $display("FAIL push_pop_empty: got c%0d d%0h un%b expected c1 d77 un%b", o_count, o_rdata, o_underflow, m_unf);
      end
      step(0, 8'h00, 1, 0, 1);
   endtask

   task automatic test_flush();
      for (int i = 0; i < 3; i++) step(1, 8'h31 + 8'(i), 0, 0, 0);
      step(1, 8'h99, 0, 1, 0);
      checks++;
      if (o_count !== 3'd0 || o_empty !== 1'b1 || o_overflow !== 1'b0 || o_underflow !== 1'b0) begin
         errors++;
         $display("FAIL flush: got c%0d e%b ov%b un%b expected c0 e1 ov0 un0", o_count, o_empty, o_overflow, o_underflow);
      end
      step(1, 8'h11, 0, 0, 0);
      checks++;
      if (o_rdata !== 8'h11 || o_count !== 3'd1) begin
         errors++;
         $display("FAIL after_flush: got d%0h c%0d expected d11 c1", o_rdata, o_count);
      end
      step(0, 8'h00, 1, 0, 0);
   endtask

   task automatic test_async_reset();
      step(1, 8'hE1, 0, 0, 0);
      step(1, 8'hE2, 0, 0, 0);
      #2;
      i_rst = 1;
      #1;
      checks++;
      if (o_empty !== 1'b1 || o_count !== 3'd0 || o_aempty !== 1'b1 || o_afull !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: got e%b c%0d ae%b af%b expected e1 c0 ae1 af0", o_empty, o_count, o_aempty, o_afull);
      end
      sb.delete();
      m_ovf = 0; m_unf = 0;
      @(negedge i_clk);
      i_rst = 0;
      step(1, 8'hF0, 0, 0, 0);
      step(1, 8'hF1, 0, 0, 0);
      step(0, 8'h00, 1, 0, 0);
      step(0, 8'h00, 1, 0, 0);
      checks++;
      if (o_empty !== 1'b1 || sb.size() != 0) begin
         errors++;
         $display("FAIL post_reset_run: got e%b expected e1", o_empty);
      end
   endtask

   initial begin
      test_reset();
      test_fill_drain();
      test_overflow();
      test_underflow();
      test_flush();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
